// File: rtl/spram_byte_ctrl.sv
// Byte-addressed tape controller in front of a 16K x 16 single-port RAM.
// Zeroes the array after reset, then serves byte writes (1/cycle) and byte reads (latency 2).
module spram_byte_ctrl #(
    parameter int DEPTH          = 16384,
    parameter bit CLEAR_ON_RESET = 1'b1,
    parameter int ADDRW          = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [ADDRW:0]   req_addr,
    input  logic [7:0]       req_wdata,
    output logic             rsp_valid,
    output logic [7:0]       rsp_rdata,
    output logic             init_done,
    output logic [3:0]       mem_we,
    output logic [ADDRW-1:0] mem_addr,
    output logic [15:0]      mem_wdata,
    input  logic [15:0]      mem_rdata
);

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        READ_WAIT
    } state_t;

    state_t           state;
    logic [ADDRW-1:0] clr_cnt;
    logic             lane_q;
    logic             hs;

    assign req_ready = (state == IDLE);
    assign hs        = req_valid & req_ready;

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        mem_we    = 4'h0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            CLEAR: begin
                mem_we   = 4'hF;
                mem_addr = clr_cnt;
            end
            IDLE: begin
                if (hs) begin
                    mem_addr  = req_addr[ADDRW:1];
                    mem_wdata = {req_wdata, req_wdata};
                    // Both bytes carry the data; the nibble mask picks the lane.
                    if (req_we) begin
                        mem_we = req_addr[0] ? 4'b1100 : 4'b0011;
                    end
                end
            end
            default: ;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments only, so every register sees pre-edge values.
    // NOTE: lane_q has no reset; it is always written on the read handshake before READ_WAIT uses it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR_ON_RESET ? CLEAR : IDLE;
            clr_cnt   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            init_done <= !CLEAR_ON_RESET;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == ADDRW'(DEPTH - 1)) begin
                        state     <= IDLE;
                        init_done <= 1'b1;
                    end
                end
                IDLE: begin
                    if (hs && !req_we) begin
                        lane_q <= req_addr[0];
                        state  <= READ_WAIT;
                    end
                end
                READ_WAIT: begin
                    rsp_rdata <= lane_q ? mem_rdata[15:8] : mem_rdata[7:0];
                    rsp_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spram_byte_ctrl.sv
// Bench for spram_byte_ctrl: two instances (with and without clear) on behavioural SPRAMs,
// directed requests with a response scoreboard checked by an independent monitor.
module tb_spram_byte_ctrl;

    localparam int DEPTH = 16384;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst       [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [14:0] req_addr  [2];
    logic [7:0]  req_wdata [2];
    logic        rsp_valid [2];
    logic [7:0]  rsp_rdata [2];
    logic        init_done [2];
    logic [3:0]  mem_we    [2];
    logic [13:0] mem_addr  [2];
    logic [15:0] mem_wdata [2];
    logic [15:0] mem_rdata [2];
    logic [15:0] ram       [2][DEPTH];

    int   cyc = 0;
    int   chk_cnt = 0;
    int   pass_cnt = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    spram_byte_ctrl #(.DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1)) dut_clr (
        .clk(clk), .rst(rst[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .init_done(init_done[0]),
        .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata[0])
    );

    spram_byte_ctrl #(.DEPTH(DEPTH), .CLEAR_ON_RESET(1'b0)) dut_noclr (
        .clk(clk), .rst(rst[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .init_done(init_done[1]),
        .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata[1])
    );

    // Behavioural SPRAMs: nibble write mask, registered read data. Preloaded with a
    // nonzero pattern so that only a real clear produces zeros.
    initial begin
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++)
                ram[d][i] <= 16'hDEAD ^ 16'(i);
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 4; n++)
                if (mem_we[d][n]) ram[d][mem_addr[d]][4*n +: 4] <= mem_wdata[d][4*n +: 4];
            mem_rdata[d] <= ram[d][mem_addr[d]];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every response pulse must match the oldest expected read, in data and cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (rsp_valid[d] === 1'b1) begin
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    check($sformatf("unexpected_rsp%0d", d), 32'(rsp_valid[d]), 32'd0);
                end else begin
                    if (d == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    check($sformatf("rsp_data%0d", d), 32'(rsp_rdata[d]), 32'(e.data));
                    check($sformatf("rsp_cycle%0d", d), 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    // Presents one request and holds it until accepted; checks the SPRAM drive in the
    // handshake cycle and queues the expected read response.
    task automatic do_req(input int d, input bit we, input logic [14:0] addr,
                          input logic [7:0] wd, input bit expect_rsp,
                          input logic [7:0] exp_rd, output int waited);
        int   stall_bad;
        exp_t e;
        waited    = 0;
        stall_bad = 0;
        @(posedge clk); #1;
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wd;
        forever begin
            @(negedge clk);
            if (req_ready[d]) break;
            if (init_done[d] && mem_we[d] != 4'h0) stall_bad++;
            waited++;
            if (waited > 64) begin
                check("accept_timeout", 32'(waited), 32'd64);
                return;
            end
        end
        if (waited > 0) check("stall_no_we", 32'(stall_bad), 32'd0);
        check("hs_mem_addr", 32'(mem_addr[d]), 32'(addr[14:1]));
        check("hs_mem_we", 32'(mem_we[d]), we ? (addr[0] ? 32'hC : 32'h3) : 32'h0);
        if (we) check("hs_mem_wdata", 32'(mem_wdata[d]), 32'({wd, wd}));
        if (expect_rsp) begin
            e.data = exp_rd;
            e.cyc  = cyc + 2;
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic idle(input int d);
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int w;
        int bad;
        int n;
        for (int d = 0; d < 2; d++) begin
            rst[d]       = 1'b1;
            req_valid[d] = 1'b0;
            req_we[d]    = 1'b0;
            req_addr[d]  = '0;
            req_wdata[d] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_init_done0", 32'(init_done[0]), 32'd0);
        check("rst_ready0", 32'(req_ready[0]), 32'd0);
        check("rst_rsp_valid0", 32'(rsp_valid[0]), 32'd0);
        check("rst_rsp_rdata0", 32'(rsp_rdata[0]), 32'd0);

        // Clear sequence, with a write to byte 5 held pending the whole time.
        @(posedge clk); #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 15'h0005;
        req_wdata[0] = 8'h77;
        bad = 0;
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            if (mem_we[0] !== 4'hF || mem_addr[0] !== 14'(k) || mem_wdata[0] !== 16'h0 ||
                req_ready[0] !== 1'b0 || init_done[0] !== 1'b0) bad++;
            if (k == 0) begin
                check("noclr_init_done", 32'(init_done[1]), 32'd1);
                check("noclr_ready", 32'(req_ready[1]), 32'd1);
            end
        end
        check("clear_seq_errors", 32'(bad), 32'd0);
        @(negedge clk);
        check("clear_init_done", 32'(init_done[0]), 32'd1);
        check("clear_ready", 32'(req_ready[0]), 32'd1);
        check("held_mem_we", 32'(mem_we[0]), 32'hC);
        check("held_mem_addr", 32'(mem_addr[0]), 32'd2);
        check("held_mem_wdata", 32'(mem_wdata[0]), 32'h7777);
        idle(0);
        @(negedge clk);
        check("held_word2", 32'(ram[0][2]), 32'h7700);

        // Byte write then reads of both lanes; the second read stalls through READ_WAIT.
        do_req(0, 1'b1, 15'h0003, 8'hA5, 1'b0, 8'h00, w);
        do_req(0, 1'b0, 15'h0002, 8'h00, 1'b1, 8'h00, w);
        do_req(0, 1'b0, 15'h0003, 8'h00, 1'b1, 8'hA5, w);
        check("read_stall_cycles", 32'(w), 32'd1);
        do_req(0, 1'b0, 15'h0005, 8'h00, 1'b1, 8'h77, w);
        do_req(0, 1'b0, 15'h0004, 8'h00, 1'b1, 8'h00, w);

        // Top-of-range back-to-back writes.
        do_req(0, 1'b1, 15'h7FFE, 8'h11, 1'b0, 8'h00, w);
        do_req(0, 1'b1, 15'h7FFF, 8'h22, 1'b0, 8'h00, w);
        check("b2b_write_wait", 32'(w), 32'd0);
        do_req(0, 1'b0, 15'h7FFF, 8'h00, 1'b1, 8'h22, w);
        do_req(0, 1'b0, 15'h7FFE, 8'h00, 1'b1, 8'h11, w);
        idle(0);
        repeat (3) @(negedge clk);
        check("word_3fff", 32'(ram[0][16383]), 32'h2211);

        // Reset lands while a read sits in READ_WAIT: no response, clear restarts.
        do_req(0, 1'b0, 15'h0003, 8'h00, 1'b0, 8'h00, w);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        rst[0]       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_rw_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("rst_rw_init_done", 32'(init_done[0]), 32'd0);
        check("rst_rw_clr_addr", 32'(mem_addr[0]), 32'd0);
        check("rst_rw_clr_we", 32'(mem_we[0]), 32'hF);
        @(posedge clk); #1;
        rst[0] = 1'b0;
        n = 0;
        while (n < 20000) begin
            @(negedge clk);
            n++;
            if (init_done[0]) break;
        end
        check("reclear_len", 32'(n), 32'(DEPTH + 1));
        do_req(0, 1'b0, 15'h0003, 8'h00, 1'b1, 8'h00, w);
        do_req(0, 1'b0, 15'h7FFF, 8'h00, 1'b1, 8'h00, w);
        do_req(0, 1'b0, 15'h0005, 8'h00, 1'b1, 8'h00, w);
        idle(0);

        // No-clear instance: write high lane, read it back, low lane keeps the preload.
        do_req(1, 1'b1, 15'h1235, 8'h5C, 1'b0, 8'h00, w);
        do_req(1, 1'b0, 15'h1235, 8'h00, 1'b1, 8'h5C, w);
        do_req(1, 1'b0, 15'h1234, 8'h00, 1'b1, 8'hB7, w);
        idle(1);

        repeat (4) @(negedge clk);
        check("pending_rsp0", 32'(q0.size()), 32'd0);
        check("pending_rsp1", 32'(q1.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
